mux_issue_ctrl: RTL and testbench

Issue controller for the two-stage registered 2:1 mux datapath. It arbitrates between two requesters (A, B) with a round-robin policy and drives the mux's A/B/Sel inputs. It tracks the mux's fixed 2-cycle latency so that every result comes out tagged with valid and source. A credit counter bounds the results in flight to a downstream consumer, and an enable/drain state machine allows a clean quiesce.

---
 rtl/mux_issue_ctrl.sv | 114 +++++++++++
 tb/tb_mux_issue_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_issue_ctrl.sv
// mux_issue_ctrl: round-robin issue control for the 2-cycle registered 2:1 mux,
// with result tagging, downstream credits and an enable/drain quiesce FSM.
module mux_issue_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int CREDITS    = 4
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic                  Enable,
   input  logic                  Req_A,
   input  logic [DATA_WIDTH-1:0] Data_A,
   output logic                  Gnt_A,
   input  logic                  Req_B,
   input  logic [DATA_WIDTH-1:0] Data_B,
   output logic                  Gnt_B,
   output logic [DATA_WIDTH-1:0] Mux_A,
   output logic [DATA_WIDTH-1:0] Mux_B,
   output logic                  Mux_Sel,
   input  logic [DATA_WIDTH-1:0] Mux_Out,
   output logic                  Out_Valid,
   output logic                  Out_Src,
   output logic [DATA_WIDTH-1:0] Out_Data,
   input  logic                  Credit_Return,
   output logic [3:0]            Credits_Avail,
   output logic                  Credit_Err,
   output logic                  Idle
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam logic [3:0] CRED_MAX = 4'(CREDITS);

   state_t     state;
   state_t     state_nxt;
   logic       last;
   logic [3:0] credits;
   logic       err;
   logic       v0;
   logic       s0;
   logic       v1;
   logic       s1;
   logic       issue;
   logic       pick_b;

   assign issue  = (state == RUN) & Enable & (credits != 4'd0)
                 & (Req_A | Req_B);
   // Under contention the requester that was not served last wins.
   assign pick_b = (Req_A & Req_B) ? ~last : Req_B;

   assign Gnt_A         = issue & ~pick_b;
   assign Gnt_B         = issue & pick_b;
   assign Mux_A         = Data_A;
   assign Mux_B         = Data_B;
   assign Mux_Sel       = Gnt_B;
   assign Out_Valid     = v1;
   assign Out_Src       = s1;
   assign Out_Data      = Mux_Out;
   assign Credits_Avail = credits;
   assign Credit_Err    = err;
   assign Idle          = (state == IDLE);

   // Leave for IDLE once stage 0 is empty: the last result is then
   // either on the output now or already gone.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (Enable) state_nxt = RUN;
         RUN:     if (!Enable) state_nxt = v0 ? DRAIN : IDLE;
         DRAIN:   if (!v0) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
         last  <= 1'b1;
      end else begin
         state <= state_nxt;
         if (issue) last <= pick_b;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         v0 <= 1'b0;
         s0 <= 1'b0;
         v1 <= 1'b0;
         s1 <= 1'b0;
      end else begin
         v0 <= issue;
         s0 <= Gnt_B;
         v1 <= v0;
         s1 <= s0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         credits <= CRED_MAX;
         err     <= 1'b0;
      end else if (issue && !Credit_Return) begin
         credits <= credits - 4'd1;
      end else if (!issue && Credit_Return) begin
         if (credits == CRED_MAX) err <= 1'b1;
         else credits <= credits + 4'd1;
      end
   end

endmodule

// File: tb/tb_mux_issue_ctrl.sv
// tb_mux_issue_ctrl: random and directed stimulus for mux_issue_ctrl,
// checked every cycle against a result-queue reference model.
module tb_mux_issue_ctrl;

   localparam int DW = 32;
   localparam int CR = 4;

   logic          Clk;
   logic          Reset_n;
   logic          Enable;
   logic          Req_A;
   logic [DW-1:0] Data_A;
   logic          Gnt_A;
   logic          Req_B;
   logic [DW-1:0] Data_B;
   logic          Gnt_B;
   logic [DW-1:0] Mux_A;
   logic [DW-1:0] Mux_B;
   logic          Mux_Sel;
   logic [DW-1:0] Mux_Out;
   logic          Out_Valid;
   logic          Out_Src;
   logic [DW-1:0] Out_Data;
   logic          Credit_Return;
   logic [3:0]    Credits_Avail;
   logic          Credit_Err;
   logic          Idle;

   int total = 0;
   int bad   = 0;

   mux_issue_ctrl #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
      .Clk(Clk), .Reset_n(Reset_n), .Enable(Enable),
      .Req_A(Req_A), .Data_A(Data_A), .Gnt_A(Gnt_A),
      .Req_B(Req_B), .Data_B(Data_B), .Gnt_B(Gnt_B),
      .Mux_A(Mux_A), .Mux_B(Mux_B), .Mux_Sel(Mux_Sel),
      .Mux_Out(Mux_Out), .Out_Valid(Out_Valid), .Out_Src(Out_Src),
      .Out_Data(Out_Data), .Credit_Return(Credit_Return),
      .Credits_Avail(Credits_Avail), .Credit_Err(Credit_Err),
      .Idle(Idle)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Two-stage registered 2:1 mux standing in for the real datapath.
   logic [DW-1:0] m0;
   logic [DW-1:0] m1;
   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m0 <= '0;
         m1 <= '0;
      end else begin
         m0 <= Mux_Sel ? Mux_B : Mux_A;
         m1 <= m0;
      end
   end
   assign Mux_Out = m1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 idle, 1 run, 2 drain; results queued with due cycle.
   typedef struct {
      int          due;
      bit          src;
      logic [31:0] data;
   } res_t;

   res_t q[$];
   int   mode = 0;
   bit   m_last = 1'b1;
   int   m_cred = CR;
   bit   m_err = 1'b0;
   int   cyc = 0;

   always @(negedge Clk) begin
      bit ea, eb, ev, es;
      logic [31:0] ed;
      if (!Reset_n) begin
         mode = 0; m_last = 1'b1; m_cred = CR; m_err = 1'b0;
         q.delete();
         chk("rst_valid", 32'(Out_Valid), 32'd0);
         chk("rst_cred", 32'(Credits_Avail), 32'(CR));
         chk("rst_idle", 32'(Idle), 32'd1);
         chk("rst_gnt", {30'd0, Gnt_A, Gnt_B}, 32'd0);
         chk("rst_err", 32'(Credit_Err), 32'd0);
      end else begin
         ea = 1'b0; eb = 1'b0;
         if (mode == 1 && Enable && m_cred > 0 && (Req_A || Req_B)) begin
            if (Req_A && Req_B) eb = (m_last == 1'b0);
            else eb = Req_B;
            ea = !eb;
         end
         ev = (q.size() > 0) && (q[0].due == cyc);
         es = ev ? q[0].src : 1'b0;
         ed = ev ? q[0].data : 32'd0;
         chk("gnt_a", 32'(Gnt_A), 32'(ea));
         chk("gnt_b", 32'(Gnt_B), 32'(eb));
         chk("mux_sel", 32'(Mux_Sel), 32'(eb));
         chk("mux_a", Mux_A, Data_A);
         chk("mux_b", Mux_B, Data_B);
         chk("out_valid", 32'(Out_Valid), 32'(ev));
         chk("out_src", 32'(Out_Src), 32'(es));
         if (ev) chk("out_data", Out_Data, ed);
         chk("credits", 32'(Credits_Avail), 32'(m_cred));
         chk("cred_err", 32'(Credit_Err), 32'(m_err));
         chk("idle", 32'(Idle), 32'(mode == 0));
         if (ev) void'(q.pop_front());
         if (ea || eb) begin
            q.push_back('{cyc + 2, eb, eb ? Data_B : Data_A});
            m_last = eb;
         end
         m_cred = m_cred + (Credit_Return ? 1 : 0) - ((ea || eb) ? 1 : 0);
         if (m_cred > CR) begin
            m_cred = CR;
            m_err = 1'b1;
         end
         case (mode)
            0: if (Enable) mode = 1;
            1: if (!Enable) mode = (q.size() == 0) ? 0 : 2;
            default: if (q.size() == 0) mode = 0;
         endcase
      end
      cyc++;
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      Enable = 1'b0; Req_A = 1'b0; Req_B = 1'b0; Credit_Return = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
   endtask

   initial begin
      bit ga, gb;
      Reset_n = 1'b0; Enable = 1'b0; Req_A = 1'b0; Req_B = 1'b0;
      Data_A = '0; Data_B = '0; Credit_Return = 1'b0;
      tick();
      tick();
      Reset_n = 1'b1;
      #2;
      chk("d_rst_cred", 32'(Credits_Avail), 32'd4);
      chk("d_rst_idle", 32'(Idle), 32'd1);

      // Single issue from A and its result two cycles later.
      Enable = 1'b1;
      tick();
      Req_A = 1'b1; Data_A = 32'h11111111;
      #2 chk("d1_gnt_a", 32'(Gnt_A), 32'd1);
      tick();
      Req_A = 1'b0;
      #2 chk("d1_cred", 32'(Credits_Avail), 32'd3);
      tick();
      #2;
      chk("d1_valid", 32'(Out_Valid), 32'd1);
      chk("d1_src", 32'(Out_Src), 32'd0);
      chk("d1_data", Out_Data, 32'h11111111);

      // Contention alternates A,B,A,B; then credit exhaustion and one return.
      do_reset();
      Enable = 1'b1;
      tick();
      Req_A = 1'b1; Req_B = 1'b1;
      Data_A = 32'hAAAA0000; Data_B = 32'hBBBB0000;
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("d2_gnt_a", 32'(Gnt_A), 32'(k % 2 == 0));
         chk("d2_gnt_b", 32'(Gnt_B), 32'(k % 2 == 1));
         if (k >= 2) chk("d2_src", 32'(Out_Src), 32'(k % 2));
         tick();
      end
      Req_B = 1'b0;
      #2;
      chk("d3_src", 32'(Out_Src), 32'd0);
      chk("d3_gnt_a0", 32'(Gnt_A), 32'd0);
      chk("d3_cred0", 32'(Credits_Avail), 32'd0);
      tick();
      Credit_Return = 1'b1;
      #2 chk("d3_src_b", 32'(Out_Src), 32'd1);
      tick();
      Credit_Return = 1'b0;
      #2 chk("d3_gnt_ret", 32'(Gnt_A), 32'd1);
      tick();
      #2 chk("d3_gnt_after", 32'(Gnt_A), 32'd0);

      // Return at full sets the sticky error; issue+return holds the count.
      do_reset();
      Credit_Return = 1'b1;
      tick();
      Credit_Return = 1'b0;
      #2;
      chk("d4_cred_full", 32'(Credits_Avail), 32'd4);
      chk("d4_err", 32'(Credit_Err), 32'd1);
      Enable = 1'b1;
      tick();
      Req_A = 1'b1;
      tick();
      tick();
      Credit_Return = 1'b1;
      #2;
      chk("d4_gnt", 32'(Gnt_A), 32'd1);
      chk("d4_cred2", 32'(Credits_Avail), 32'd2);
      tick();
      Credit_Return = 1'b0; Req_A = 1'b0;
      #2;
      chk("d4_cred_same", 32'(Credits_Avail), 32'd2);
      chk("d4_err_stick", 32'(Credit_Err), 32'd1);

      // Drain with two results in flight; Enable during drain is ignored.
      do_reset();
      Enable = 1'b1;
      tick();
      Req_A = 1'b1;
      tick();
      tick();
      Enable = 1'b0;
      #2;
      chk("d5_nogrant", 32'(Gnt_A), 32'd0);
      chk("d5_valid1", 32'(Out_Valid), 32'd1);
      tick();
      Enable = 1'b1;
      #2;
      chk("d5_drain", 32'(Idle), 32'd0);
      chk("d5_valid2", 32'(Out_Valid), 32'd1);
      chk("d5_gnt_drain", 32'(Gnt_A), 32'd0);
      tick();
      #2;
      chk("d5_idle", 32'(Idle), 32'd1);
      chk("d5_valid_off", 32'(Out_Valid), 32'd0);
      chk("d5_gnt_idle", 32'(Gnt_A), 32'd0);
      tick();
      #2 chk("d5_rerun", 32'(Gnt_A), 32'd1);

      // Asynchronous reset with one result in flight.
      do_reset();
      Enable = 1'b1;
      tick();
      Req_A = 1'b1; Data_A = 32'h12345678;
      tick();
      Req_A = 1'b0; Enable = 1'b0;
      #1 Reset_n = 1'b0;
      #1;
      chk("d6_valid", 32'(Out_Valid), 32'd0);
      chk("d6_cred", 32'(Credits_Avail), 32'd4);
      chk("d6_idle", 32'(Idle), 32'd1);
      tick();
      Reset_n = 1'b1;
      #2 chk("d6_dropped", 32'(Out_Valid), 32'd0);
      tick();
      #2 chk("d6_dropped2", 32'(Out_Valid), 32'd0);

      // Randomized traffic.
      do_reset();
      Enable = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge Clk);
         ga = Gnt_A; gb = Gnt_B;
         tick();
         if (!Reset_n) Reset_n = 1'b1;
         else if ($urandom_range(0, 499) == 0) Reset_n = 1'b0;
         if (ga || !Req_A) begin
            Req_A = ($urandom_range(0, 2) != 0);
            Data_A = $urandom;
         end
         if (gb || !Req_B) begin
            Req_B = ($urandom_range(0, 2) != 0);
            Data_B = $urandom;
         end
         if ($urandom_range(0, 24) == 0) Enable = !Enable;
         Credit_Return = ($urandom_range(0, 2) == 0);
      end
      Req_A = 1'b0; Req_B = 1'b0; Credit_Return = 1'b0; Enable = 1'b0;
      repeat (4) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
